// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and phase constants for the super-res VRAM arbiter.
//   owner_t    : slot owner encoding (NONE/DISP/CPU/CMD)
//   state_t    : per-slot FSM state
//   PH_*       : cx[1:0] phase values for the AP/FS/DL/DR cadence
//   vram_req_t : latched slot request {wr, addr, wdata, be}
package vram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_CMD  = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] PH_AP = 2'd2;
    localparam logic [1:0] PH_FS = 2'd3;
    localparam logic [1:0] PH_DL = 2'd0;
    localparam logic [1:0] PH_DR = 2'd1;

    // Address field sized for the widest supported ADDR_W; the top uses the low bits.
    localparam int MAX_ADDR_W = 32;

    typedef struct packed {
        logic                  wr;
        logic [MAX_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            be;
    } vram_req_t;

endpackage

// File: rtl/vdp_vram_rr_pick.sv
// vdp_vram_rr_pick: two-input round-robin picker for the CPU/command engine slots.
//   clk, reset_n       : clock, async active-low reset (pointer clears to A)
//   en_i               : decision is taken this cycle; pointer updates on a grant
//   a_req_i, b_req_i   : competing requests (A=CPU, B=CMD)
//   grant_a_o/grant_b_o: one-hot grant (both low when nobody requests)
//   rr_ptr_o           : preferred side on a tie, 0=A, 1=B
module vdp_vram_rr_pick (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic grant_a_o,
    output logic grant_b_o,
    output logic rr_ptr_o
);

    logic rr_ptr_q, rr_ptr_d;

    assign grant_a_o = a_req_i & (~b_req_i | ~rr_ptr_q);
    assign grant_b_o = b_req_i & (~a_req_i | rr_ptr_q);
    assign rr_ptr_o  = rr_ptr_q;

    // After a grant the pointer favours the side that lost.
    always_comb begin
        rr_ptr_d = (en_i && (grant_a_o || grant_b_o)) ? grant_a_o : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rr_ptr_q <= 1'b0;
        else          rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/vdp_super_vram_arbiter.sv
// vdp_super_vram_arbiter: shares one 32-bit VRAM port between display fetch, CPU and
// command engine, one access per 4-clock slot locked to cx[1:0] (AP/FS/DL/DR).
//   clk, reset_n                 : pixel clock, async active-low reset
//   cx                           : pixel column, bits [1:0] give the slot phase
//   disp_req/disp_addr           : display fetch request (absolute priority, read only)
//   disp_valid/disp_rdata        : display data, valid for one cycle at the next AP
//   cpu_*/cmd_*                  : req/wr/addr/wdata/be in, ack/rdata out (round-robin)
//   vram_addr/wdata/be           : SDRAM command fields, held between slots
//   vram_rd/vram_wr              : one-cycle strobes in FS
//   vram_rdata                   : SDRAM read data, sampled in DR
//   owner                        : current slot owner (debug)
module vdp_super_vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [10:0]       cx,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [31:0]       disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    input  logic              cmd_req,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_be,
    output logic              cmd_ack,
    output logic [31:0]       cmd_rdata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_rd,
    output logic              vram_wr,
    output logic [31:0]       vram_wdata,
    output logic [3:0]        vram_be,
    input  logic [31:0]       vram_rdata,
    output logic [1:0]        owner
);

    logic [1:0]  ph;
    state_t      state_q, state_d;
    owner_t      owner_q, owner_d, win;
    vram_req_t   slot_q, slot_d, win_req;
    logic [31:0] cpu_rdata_q, cpu_rdata_d, cmd_rdata_q, cmd_rdata_d, disp_rdata_q, disp_rdata_d;
    logic        cpu_ack_q, cpu_ack_d, cmd_ack_q, cmd_ack_d, disp_valid_q, disp_valid_d;
    logic        grant_cpu, grant_cmd, rr_ptr;
    logic [1:0]  exp_ph;
    logic [ADDR_W-1:0] sel_addr;
    logic        unused_bits;

    assign ph          = cx[1:0];
    assign unused_bits = ^{cx[10:2], slot_q.addr, rr_ptr};

    vdp_vram_rr_pick u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (ph == PH_AP && !disp_req),
        .a_req_i   (cpu_req),
        .b_req_i   (cmd_req),
        .grant_a_o (grant_cpu),
        .grant_b_o (grant_cmd),
        .rr_ptr_o  (rr_ptr)
    );

    assign win = disp_req ? OWN_DISP : grant_cpu ? OWN_CPU : grant_cmd ? OWN_CMD : OWN_NONE;

    // Display slots reuse the held write data so vram_wdata only moves on CPU/CMD slots.
    always_comb begin
        sel_addr      = (win == OWN_CPU) ? cpu_addr : (win == OWN_CMD) ? cmd_addr : disp_addr;
        win_req.wr    = (win == OWN_CPU) ? cpu_wr : (win == OWN_CMD) ? cmd_wr : 1'b0;
        win_req.addr  = MAX_ADDR_W'({sel_addr[ADDR_W-1:1], 1'b0});
        win_req.wdata = (win == OWN_CPU) ? cpu_wdata : (win == OWN_CMD) ? cmd_wdata : slot_q.wdata;
        win_req.be    = (win == OWN_CPU) ? cpu_be : (win == OWN_CMD) ? cmd_be : 4'hF;
    end

    // Phase each in-flight state must see; any other phase means cx jumped.
    assign exp_ph = (state_q == ST_CMD) ? PH_FS : (state_q == ST_DATA) ? PH_DL : PH_DR;

    always_comb begin
        state_d      = ST_IDLE;
        owner_d      = owner_q;
        slot_d       = slot_q;
        cpu_rdata_d  = cpu_rdata_q;
        cmd_rdata_d  = cmd_rdata_q;
        disp_rdata_d = disp_rdata_q;
        cpu_ack_d    = 1'b0;
        cmd_ack_d    = 1'b0;
        disp_valid_d = 1'b0;
        if (ph == PH_AP) begin
            owner_d = win;
            state_d = (win == OWN_NONE) ? ST_IDLE : ST_CMD;
            if (win != OWN_NONE) slot_d = win_req;
        end else if (state_q != ST_IDLE) begin
            if (ph != exp_ph) begin
                owner_d = OWN_NONE;
            end else if (state_q != ST_DONE) begin
                state_d = (state_q == ST_CMD) ? ST_DATA : ST_DONE;
            end else begin
                disp_valid_d = (owner_q == OWN_DISP);
                cpu_ack_d    = (owner_q == OWN_CPU);
                cmd_ack_d    = (owner_q == OWN_CMD);
                disp_rdata_d = (owner_q == OWN_DISP && !slot_q.wr) ? vram_rdata : disp_rdata_q;
                cpu_rdata_d  = (owner_q == OWN_CPU && !slot_q.wr) ? vram_rdata : cpu_rdata_q;
                cmd_rdata_d  = (owner_q == OWN_CMD && !slot_q.wr) ? vram_rdata : cmd_rdata_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            slot_q       <= '0;
            cpu_rdata_q  <= '0;
            cmd_rdata_q  <= '0;
            disp_rdata_q <= '0;
            cpu_ack_q    <= 1'b0;
            cmd_ack_q    <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            slot_q       <= slot_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cmd_rdata_q  <= cmd_rdata_d;
            disp_rdata_q <= disp_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cmd_ack_q    <= cmd_ack_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    // Strobes need both the CMD state and the FS phase, so a skipped FS never fires.
    assign vram_rd    = (state_q == ST_CMD) && (ph == PH_FS) && !slot_q.wr;
    assign vram_wr    = (state_q == ST_CMD) && (ph == PH_FS) && slot_q.wr;
    assign vram_addr  = slot_q.addr[ADDR_W-1:0];
    assign vram_wdata = slot_q.wdata;
    assign vram_be    = slot_q.be;
    assign owner      = owner_q;
    assign cpu_ack    = cpu_ack_q;
    assign cmd_ack    = cmd_ack_q;
    assign disp_valid = disp_valid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cmd_rdata  = cmd_rdata_q;
    assign disp_rdata = disp_rdata_q;

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// tb_vdp_super_vram_arbiter: directed self-checking bench for vdp_super_vram_arbiter.
module tb_vdp_super_vram_arbiter;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [10:0]   cx = '0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_valid;
    logic [31:0]   disp_rdata;
    logic          cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [3:0]    cpu_be = 4'hF;
    logic          cpu_ack;
    logic [31:0]   cpu_rdata;
    logic          cmd_req = 1'b0, cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_be = 4'hF;
    logic          cmd_ack;
    logic [31:0]   cmd_rdata;
    logic [AW-1:0] vram_addr;
    logic          vram_rd, vram_wr;
    logic [31:0]   vram_wdata;
    logic [3:0]    vram_be;
    logic [31:0]   vram_rdata = '0;
    logic [1:0]    owner;

    int checks = 0;
    int errors = 0;

    vdp_super_vram_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .cx(cx),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
        .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_wr(vram_wr), .vram_wdata(vram_wdata),
        .vram_be(vram_be), .vram_rdata(vram_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one clock: cx steps 1ns after the edge, return a few ns later (mid-cycle).
    task automatic next();
        @(posedge clk);
        #1 cx = cx + 11'd1;
        #3;
    endtask

    task automatic goto_ph(input logic [1:0] ph);
        next();
        while (cx[1:0] != ph) next();
    endtask

    task automatic reset_dut();
        {disp_req, cpu_req, cmd_req, cpu_wr, cmd_wr} = '0;
        reset_n = 1'b0;
        next();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        next();
        checks++;
        if ({vram_rd, vram_wr, vram_addr, vram_wdata, vram_be, owner, cpu_ack, cmd_ack, disp_valid,
             cpu_rdata, cmd_rdata, disp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b wr=%b addr=%h wdata=%h be=%h owner=%0d acks=%b%b%b rdata=%h/%h/%h, required all 0",
                     vram_rd, vram_wr, vram_addr, vram_wdata, vram_be, owner, cpu_ack, cmd_ack, disp_valid,
                     cpu_rdata, cmd_rdata, disp_rdata);
        end
        reset_n = 1'b1;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 17'h00101;
        vram_rdata = 32'h0BAD_0BAD;
        goto_ph(2'd2);
        next();
        checks++;
        if ({vram_rd, vram_wr, vram_addr, owner} !== {1'b1, 1'b0, 17'h00100, 2'd2}) begin
            errors++;
            $display("FAIL reset_first_fs: rd=%b wr=%b addr=%h owner=%0d, required rd=1 wr=0 addr=00100 owner=2",
                     vram_rd, vram_wr, vram_addr, owner);
        end
        next();
        checks++;
        if (vram_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_dl_strobe: vram_rd=%b required 0", vram_rd);
        end
        next();
        vram_rdata = 32'h1234_5678;
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_dr_ack: cpu_ack=%b required 0", cpu_ack);
        end
        cpu_req = 1'b0;
        next();
        vram_rdata = 32'h0BAD_0BAD;
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL reset_ack: ack=%b rdata=%h, required ack=1 rdata=12345678", cpu_ack, cpu_rdata);
        end
        next();
        checks++;
        if ({cpu_ack, vram_rd, vram_addr} !== {1'b0, 1'b0, 17'h00100}) begin
            errors++;
            $display("FAIL reset_after: ack=%b rd=%b addr=%h, required ack=0 rd=0 addr=00100 held",
                     cpu_ack, vram_rd, vram_addr);
        end
    endtask

    task automatic test_priority();
        logic [1:0] exp_own [3] = '{2'd2, 2'd3, 2'd2};
        reset_dut();
        disp_req = 1'b1; disp_addr = 17'h00201;
        cpu_req = 1'b1; cpu_addr = 17'h00010;
        cmd_req = 1'b1; cmd_addr = 17'h00020;
        vram_rdata = 32'h5A5A_5A5A;
        for (int s = 0; s < 3; s++) begin
            goto_ph(2'd2);
            checks++;
            if ({cpu_ack, cmd_ack} !== 2'b00) begin
                errors++;
                $display("FAIL prio_stall_ack slot %0d: cpu_ack=%b cmd_ack=%b, required 0 0", s, cpu_ack, cmd_ack);
            end
            next();
            checks++;
            if ({owner, vram_rd, vram_addr, vram_be} !== {2'd1, 1'b1, 17'h00200, 4'hF}) begin
                errors++;
                $display("FAIL prio_disp slot %0d: owner=%0d rd=%b addr=%h be=%h, required 1 1 00200 f",
                         s, owner, vram_rd, vram_addr, vram_be);
            end
        end
        goto_ph(2'd2);
        checks++;
        if ({disp_valid, disp_rdata, cpu_ack, cmd_ack} !== {1'b1, 32'h5A5A_5A5A, 2'b00}) begin
            errors++;
            $display("FAIL prio_disp_valid: valid=%b rdata=%h acks=%b%b, required 1 5a5a5a5a 00",
                     disp_valid, disp_rdata, cpu_ack, cmd_ack);
        end
        disp_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next();
            checks++;
            if ({owner, vram_addr} !== {exp_own[i], (exp_own[i] == 2'd2) ? 17'h00010 : 17'h00020}) begin
                errors++;
                $display("FAIL prio_rr slot %0d: owner=%0d addr=%h, required owner=%0d", i, owner, vram_addr, exp_own[i]);
            end
            goto_ph(2'd2);
            checks++;
            if ({cpu_ack, cmd_ack} !== {exp_own[i] == 2'd2, exp_own[i] == 2'd3}) begin
                errors++;
                $display("FAIL prio_rr_ack slot %0d: cpu_ack=%b cmd_ack=%b, required owner %0d acked",
                         i, cpu_ack, cmd_ack, exp_own[i]);
            end
        end
        cpu_req = 1'b0; cmd_req = 1'b0;
    endtask

    task automatic test_write();
        reset_dut();
        cmd_req = 1'b1; cmd_wr = 1'b1; cmd_be = 4'b0101; cmd_wdata = 32'hDEAD_BEEF; cmd_addr = 17'h00333;
        vram_rdata = 32'hCAFE_F00D;
        goto_ph(2'd2);
        next();
        checks++;
        if ({vram_wr, vram_rd, vram_be, vram_wdata, vram_addr, owner} !==
            {1'b1, 1'b0, 4'b0101, 32'hDEAD_BEEF, 17'h00332, 2'd3}) begin
            errors++;
            $display("FAIL write_fs: wr=%b rd=%b be=%b wdata=%h addr=%h owner=%0d, required 1 0 0101 deadbeef 00332 3",
                     vram_wr, vram_rd, vram_be, vram_wdata, vram_addr, owner);
        end
        next();
        checks++;
        if (vram_wr !== 1'b0) begin
            errors++;
            $display("FAIL write_single_strobe: vram_wr=%b in DL, required 0", vram_wr);
        end
        next();
        cmd_req = 1'b0;
        checks++;
        if (cmd_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_early_ack: cmd_ack=%b in DR, required 0", cmd_ack);
        end
        next();
        checks++;
        if ({cmd_ack, cmd_rdata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL write_ack: ack=%b rdata=%h, required ack=1 rdata=00000000", cmd_ack, cmd_rdata);
        end
        cmd_wr = 1'b0;
    endtask

    task automatic test_late();
        reset_dut();
        vram_rdata = 32'h0;
        goto_ph(2'd3);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 17'h00041;
        next();
        next();
        checks++;
        if ({vram_rd, owner} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL late_no_midslot: rd=%b owner=%0d in DR, required 0 0", vram_rd, owner);
        end
        next();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL late_no_ack: cpu_ack=%b at first AP, required 0", cpu_ack);
        end
        next();
        checks++;
        if ({vram_rd, vram_addr} !== {1'b1, 17'h00040}) begin
            errors++;
            $display("FAIL late_grant: rd=%b addr=%h, required 1 00040", vram_rd, vram_addr);
        end
        next();
        next();
        vram_rdata = 32'h7777_1234;
        cpu_req = 1'b0;
        next();
        vram_rdata = 32'h0;
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 32'h7777_1234}) begin
            errors++;
            $display("FAIL late_ack: ack=%b rdata=%h, required 1 77771234", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 17'h00081;
        vram_rdata = 32'h9999_0000;
        goto_ph(2'd2);
        next();
        next();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({owner, vram_rd, cpu_ack} !== {2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_async: owner=%0d rd=%b ack=%b during reset, required 0 0 0", owner, vram_rd, cpu_ack);
        end
        next();
        reset_n = 1'b1;
        next();
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rstmid_no_ack: ack=%b rdata=%h, required 0 00000000", cpu_ack, cpu_rdata);
        end
        next();
        checks++;
        if ({vram_rd, vram_addr} !== {1'b1, 17'h00080}) begin
            errors++;
            $display("FAIL rstmid_reissue: rd=%b addr=%h, required 1 00080", vram_rd, vram_addr);
        end
        next();
        next();
        cpu_req = 1'b0;
        next();
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 32'h9999_0000}) begin
            errors++;
            $display("FAIL rstmid_ack: ack=%b rdata=%h, required 1 99990000", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_phase_jump();
        reset_dut();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 17'h00011;
        vram_rdata = 32'h1111_2222;
        goto_ph(2'd2);
        next();
        @(posedge clk);
        #1 cx = {cx[10:2], 2'b10};
        #3;
        checks++;
        if ({vram_rd, cpu_ack, cpu_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL jump_fs_ap: rd=%b ack=%b rdata=%h, required 0 0 00000000", vram_rd, cpu_ack, cpu_rdata);
        end
        next();
        checks++;
        if ({vram_rd, owner} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL jump_fresh_grant: rd=%b owner=%0d, required 1 2", vram_rd, owner);
        end
        @(posedge clk);
        #1 cx = {cx[10:2], 2'b01};
        #3;
        next();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL jump_fs_dr: cpu_ack=%b after skipped DL, required 0", cpu_ack);
        end
        next();
        next();
        next();
        cpu_req = 1'b0;
        next();
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 32'h1111_2222}) begin
            errors++;
            $display("FAIL jump_recover: ack=%b rdata=%h, required 1 11112222", cpu_ack, cpu_rdata);
        end
        goto_ph(2'd2);
        checks++;
        if ({cpu_ack, owner} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL jump_no_extra: ack=%b owner=%0d, required 0 0", cpu_ack, owner);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_write();
        test_late();
        test_reset_mid();
        test_phase_jump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
